// File: rtl/branch_resolve.sv
// Branch/jump resolve stage: one output register, zero test,
// taken decision, redirect pulse and a squash window after taken.
module branch_resolve #(
  parameter int WIDTH       = 32,
  parameter int FLUSH_SLOTS = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_branch,
  input  logic             branch_on_zero,
  input  logic             is_jump,
  input  logic [WIDTH-1:0] operand,
  input  logic [31:0]      target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_operand,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush
);

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  localparam logic [2:0] SLOTS = 3'(FLUSH_SLOTS);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             vld_q, br_q, bz_q, jp_q;
  logic [WIDTH-1:0] op_q;
  logic [31:0]      tg_q;
  logic             redir_q;
  logic [31:0]      rpc_q;

  logic accept, xfer, zero, taken;
  logic taken_xfer, sq, load;

  assign in_ready   = ~vld_q | out_ready;
  assign accept     = in_valid & in_ready;
  assign xfer       = vld_q & out_ready;
  assign zero       = ~|op_q;
  assign taken      = vld_q &
                      (jp_q | (br_q & (zero == bz_q)));
  assign taken_xfer = taken & out_ready;
  assign sq         = (state_q == S_FLUSH) | taken_xfer;
  assign load       = accept & ~sq;

  assign out_valid   = vld_q;
  assign out_taken   = taken;
  assign out_zero    = vld_q & zero;
  assign out_operand = op_q;
  assign redirect    = redir_q;
  assign redirect_pc = rpc_q;
  assign flush       = (state_q == S_FLUSH);

  // Output register: load unsquashed accepts, clear on transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      br_q  <= 1'b0;
      bz_q  <= 1'b0;
      jp_q  <= 1'b0;
      op_q  <= '0;
      tg_q  <= '0;
    end else begin
      if (load) begin
        vld_q <= 1'b1;
        br_q  <= is_branch;
        bz_q  <= branch_on_zero;
        jp_q  <= is_jump;
        op_q  <= operand;
        tg_q  <= target;
      end else if (xfer) begin
        vld_q <= 1'b0;
      end
    end
  end

  // One-cycle redirect pulse after a taken instruction leaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redir_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      redir_q <= taken_xfer;
      if (taken_xfer) begin
        rpc_q <= tg_q;
      end
    end
  end

  // Squash FSM state and slot counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Open the window on taken transfer; each accept uses a slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    priority case (1'b1)
      taken_xfer: begin
        cnt_d   = SLOTS - 3'(accept);
        state_d = (cnt_d != 3'd0) ? S_FLUSH : S_IDLE;
      end
      (state_q == S_FLUSH) && accept: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter WIDTH, default 32: operand width tested for zero.
REQ-002 Parameter FLUSH_SLOTS, default 2, legal range 1..7: number of younger accepted instructions squashed after a taken redirect.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream holds a valid instruction.
REQ-006 in_ready  output  1  block can accept this cycle.
REQ-007 is_branch  input  1  conditional branch.
REQ-008 branch_on_zero  input  1  1 = BEQZ, 0 = BNEZ; don't-care when is_branch=0.
REQ-009 is_jump  input  1  unconditional jump.
REQ-010 operand  input  WIDTH  register value tested for zero.
REQ-011 target  input  32  branch/jump destination.
REQ-012 out_valid  output  1  output register holds an instruction.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 out_taken  output  1  held instruction redirects.
REQ-015 out_zero  output  1  registered operand == 0.
REQ-016 out_operand  output  WIDTH  registered operand, passed through.
REQ-017 redirect  output  1  one-cycle fetch redirect pulse.
REQ-018 redirect_pc  output  32  redirect destination; valid while redirect=1.
REQ-019 flush  output  1  squash window active.

Function
REQ-020 Single output register stage: accept = in_valid & in_ready; in_ready = ~out_valid | out_ready (combinational, no dependence on in_valid).
REQ-021 Transfer out = out_valid & out_ready; with no accept, out_valid clears on transfer and holds otherwise; fields are stable while out_valid=1 and out_ready=0.
REQ-022 out_zero = NOR of all WIDTH bits of the registered operand, computed from the register, never from the live input.
REQ-023 out_taken = is_jump | (is_branch & (out_zero == branch_on_zero)), from registered fields; is_jump takes priority.
REQ-024 taken_xfer = transfer out of an instruction with out_taken=1.
REQ-025 FSM states IDLE and FLUSH; 3-bit counter cnt.
REQ-026 Squash condition sq = (state==FLUSH) | taken_xfer.
REQ-027 An accept while sq=1 discards the input (not loaded; out_valid becomes 0 unless it was already 0 and stays 0), and consumes one slot.
REQ-028 On taken_xfer in cycle T: the next cycle has redirect=1 with redirect_pc = that instruction's target; cnt = FLUSH_SLOTS - (accept in T ? 1 : 0); state = FLUSH if that value > 0, else IDLE.
REQ-029 In FLUSH, each accept decrements cnt; when cnt reaches 0, state returns to IDLE on that edge.
REQ-030 In FLUSH, a transfer out of an already-held instruction is allowed; it cannot be taken because squashed inputs are never loaded.
REQ-031 flush = (state==FLUSH), registered.
REQ-032 redirect is exactly one cycle per taken_xfer, with no dependence on out_ready after T.
REQ-033 A not-taken branch or a non-branch instruction causes no redirect and no state change.

Reset
REQ-034 When reset_n=0, the following clear immediately, regardless of clk: out_valid=0, out_taken=0, out_zero=0, out_operand=0, redirect=0, redirect_pc=0, flush=0, state=IDLE, cnt=0.
REQ-035 A reset asserted mid-FLUSH abandons the remaining squash; after reset deasserts, the first accept is loaded normally.
REQ-036 in_ready=1 during and immediately after reset.

Verification
REQ-037 BEQZ, operand=0, target=0x100, out_ready=1 -> out_taken=1, out_zero=1; next cycle redirect=1, redirect_pc=0x100, flush=1; the next 2 accepts are discarded; flush=0 after the 2nd.
REQ-038 BNEZ, operand=0x00000001 -> out_taken=1; same BNEZ with operand=0 -> out_taken=0, no redirect, following instruction is loaded.
REQ-039 Taken jump with in_valid=1 in the same cycle as its transfer, FLUSH_SLOTS=1 -> redirect pulses once, the concurrent input is discarded, flush stays 0, state=IDLE.
REQ-040 Backpressure: out_ready=0 for 3 cycles with a taken branch held -> in_ready=0, outputs stable, no redirect until the transfer; the redirect follows one cycle after the transfer.
REQ-041 Operand 0x80000000 and operand 0xFFFFFFFF -> out_zero=0; operand 0x00000000 -> out_zero=1.
REQ-042 reset_n pulsed low asynchronously while flush=1 with cnt=1 -> all outputs are 0 immediately; the first post-reset accept is loaded with out_valid=1.
